// File: rtl/edge_pulse_gen.sv
// Programmable pulse-train generator: accepts a mask/high/low/count command and
// drives rising-edge patterns on an 8-bit level bus, then strobes done.
module edge_pulse_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_high,
    input  logic [CNT_W-1:0] cmd_low,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] pulse_out,
    output logic             rise_strobe,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] MASK_ZERO = WIDTH'(0);

    // A zero-length phase still occupies one cycle.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
        return (len == CNT_ZERO) ? CNT_ONE : len;
    endfunction

    state_e           state_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] pulse_q;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] low_q;
    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] remain_q;
    logic             ready_q;
    logic             rise_q;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] high_eff_d;
    logic [CNT_W-1:0] low_eff_d;
    logic [CNT_W-1:0] phase_dec_d;
    logic [CNT_W-1:0] remain_dec_d;
    logic             accept_d;
    logic             phase_end_d;

    // Next-value helpers shared by the FSM.
    always_comb begin
        high_eff_d   = clamp_len(cmd_high);
        low_eff_d    = clamp_len(cmd_low);
        phase_dec_d  = phase_q - CNT_ONE;
        remain_dec_d = remain_q - CNT_ONE;
        accept_d     = cmd_valid && ready_q && (state_q == S_IDLE);
        phase_end_d  = (phase_q <= CNT_ONE);
    end

    // Pulse-train FSM; outputs are registered so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mask_q   <= MASK_ZERO;
            pulse_q  <= MASK_ZERO;
            high_q   <= CNT_ONE;
            low_q    <= CNT_ONE;
            phase_q  <= CNT_ZERO;
            remain_q <= CNT_ZERO;
            ready_q  <= 1'b0;
            rise_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d && (cmd_count == CNT_ZERO)) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        pulse_q <= MASK_ZERO;
                    end else if (accept_d) begin
                        state_q  <= S_HIGH;
                        mask_q   <= cmd_mask;
                        high_q   <= high_eff_d;
                        low_q    <= low_eff_d;
                        phase_q  <= high_eff_d;
                        remain_q <= cmd_count;
                        pulse_q  <= cmd_mask;
                        rise_q   <= |cmd_mask;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        pulse_q <= MASK_ZERO;
                    end
                end
                S_HIGH: begin
                    if (phase_end_d) begin
                        state_q  <= S_LOW;
                        phase_q  <= low_q;
                        remain_q <= remain_dec_d;
                        pulse_q  <= MASK_ZERO;
                    end else begin
                        phase_q <= phase_dec_d;
                    end
                end
                S_LOW: begin
                    // The last low phase hands over to IDLE, whose first cycle carries done.
                    if (phase_end_d && (remain_q == CNT_ZERO)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else if (phase_end_d) begin
                        state_q <= S_HIGH;
                        phase_q <= high_q;
                        pulse_q <= mask_q;
                        rise_q  <= |mask_q;
                    end else begin
                        phase_q <= phase_dec_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    pulse_q <= MASK_ZERO;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = ready_q;
    assign pulse_out   = pulse_q;
    assign rise_strobe = rise_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
